word_narrow_serializer: RTL

- Inverse of the byte-to-word sign extension path: takes a 32-bit word and narrows it back onto the 8-bit datapath.
- Two modes:
  - Serialize mode: emits all four bytes over an 8-bit valid/ready stream.
  - Narrow mode: emits one byte and flags whether the word fitted in a sign-extended 8-bit value.
- Sits between the 32-bit offset/memory-word side and the 8-bit register-file/data-memory side of the processor.

---
 rtl/word_narrow_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/word_narrow_serializer.sv
`default_nettype none
//==============================================================================
// Module      : word_narrow_serializer
// Description : Narrows a multi-byte word onto an 8-bit valid/ready stream,
//               either serializing every byte or emitting one narrowed byte
//               with a signed-8-bit overflow flag. Optional macro
//               NARROW_SATURATE_EN saturates out-of-range narrowed values.
// Revision    : 1.0 - initial release
//==============================================================================
module word_narrow_serializer #(
    parameter int WORD_BYTES = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*WORD_BYTES-1:0] in_word,
    input  logic                    in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    ovf,
    output logic                    busy
);

    localparam int c_W  = 8 * WORD_BYTES;
    localparam int c_CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WORD_BYTES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [c_W-1:0]  r_word;
    logic            r_mode;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic [7:0]      r_narrow_byte;

    logic            w_fit;
    logic            w_capture;
    logic            w_xfer;
    logic            w_last;
    logic [7:0]      w_narrow_byte;
    logic [c_CW-1:0] w_idx;

    // Word fits a sign-extended byte when bits above bit 6 all match
    assign w_fit = (&in_word[c_W-1:7]) | ~(|in_word[c_W-1:7]);

`ifdef NARROW_SATURATE_EN
    assign w_narrow_byte = w_fit ? in_word[7:0]
                                 : (in_word[c_W-1] ? 8'h80 : 8'h7F);
`else
    assign w_narrow_byte = in_word[7:0];
`endif

    assign w_idx     = MSB_FIRST ? (c_LAST - r_count) : r_count;
    assign w_capture = (r_state == S_IDLE) && in_valid;
    assign w_xfer    = (r_state == S_SEND) && out_ready;
    assign w_last    = r_mode || (r_count == c_LAST);
    assign ovf       = r_ovf;

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_byte     = 8'h00;
        out_last     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = w_last;
                out_byte  = r_mode ? r_narrow_byte : r_word[{w_idx, 3'b000} +: 8];
                if (out_ready && w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_mode        <= 1'b0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_narrow_byte <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_word        <= in_word;
                r_mode        <= in_mode;
                r_count       <= '0;
                r_ovf         <= in_mode & ~w_fit;
                r_narrow_byte <= w_narrow_byte;
            end else if (w_xfer) begin
                // Count returns to zero only through the final transfer
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
